// File: rtl/otter_mem_arbiter_if.sv
// rtl/otter_mem_arbiter_if.sv - bus bundle between CPU/DMA requesters, the arbiter and the memory data port
//
// Purpose: groups every handshake and data-port signal of the memory arbiter.
// Signals:
//   CPU_* / DMA_*   requester side: REQ, WE, ADDR, DIN, SIZE, SIGN in; GNT, RVALID, RDATA out
//   MEM_*           memory side: ADDR2, DIN2, WRITE2, READ2, SIZE, SIGN out; DOUT2 in
// Modports:
//   slave   arbiter view
//   master  requester/memory view (testbench side)

interface otter_mem_arbiter_if;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_DIN;
  logic [1:0]  CPU_SIZE;
  logic        CPU_SIGN;
  logic        CPU_GNT;
  logic        CPU_RVALID;
  logic [31:0] CPU_RDATA;

  logic        DMA_REQ;
  logic        DMA_WE;
  logic [31:0] DMA_ADDR;
  logic [31:0] DMA_DIN;
  logic [1:0]  DMA_SIZE;
  logic        DMA_SIGN;
  logic        DMA_GNT;
  logic        DMA_RVALID;
  logic [31:0] DMA_RDATA;

  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN,
    input  MEM_DOUT2,
    output CPU_GNT, CPU_RVALID, CPU_RDATA,
    output DMA_GNT, DMA_RVALID, DMA_RDATA,
    output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    output DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN,
    output MEM_DOUT2,
    input  CPU_GNT, CPU_RVALID, CPU_RDATA,
    input  DMA_GNT, DMA_RVALID, DMA_RDATA,
    input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - two-requester (CPU/DMA) arbiter for a single memory data port
//
// Purpose: grants at most one of CPU/DMA per cycle, CPU first, but lets DMA in
// after CPU_BURST_MAX consecutive CPU grants taken while DMA was waiting.
// The winner's request is muxed combinationally onto the memory port; loads
// return one cycle later on the owner's RVALID.
// Ports:
//   MEM_CLK    clock, rising edge
//   MEM_RST_N  synchronous active-low reset
//   bus        otter_mem_arbiter_if.slave (requester and memory signals)

module otter_mem_arbiter #(
  parameter int CPU_BURST_MAX = 4
) (
  input logic                  MEM_CLK,
  input logic                  MEM_RST_N,
  otter_mem_arbiter_if.slave   bus
);

  localparam logic [3:0] BURST_MAX = 4'(CPU_BURST_MAX);

  logic [3:0] burst_cnt;
  logic       rd_pend;
  logic       rd_owner;   // 0 = CPU, 1 = DMA
  logic       cpu_gnt;
  logic       dma_gnt;

  // DMA wins if CPU is idle, or if the CPU has used up its burst allowance.
  always_comb begin
    dma_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (MEM_RST_N) begin
      dma_gnt = bus.DMA_REQ && (!bus.CPU_REQ || burst_cnt == BURST_MAX);
      cpu_gnt = bus.CPU_REQ && !dma_gnt;
    end
  end

  always_comb begin
    bus.MEM_ADDR2  = 32'd0;
    bus.MEM_DIN2   = 32'd0;
    bus.MEM_WRITE2 = 1'b0;
    bus.MEM_READ2  = 1'b0;
    bus.MEM_SIZE   = 2'd0;
    bus.MEM_SIGN   = 1'b0;
    if (cpu_gnt) begin
      bus.MEM_ADDR2  = bus.CPU_ADDR;
      bus.MEM_DIN2   = bus.CPU_DIN;
      bus.MEM_WRITE2 = bus.CPU_WE;
      bus.MEM_READ2  = !bus.CPU_WE;
      bus.MEM_SIZE   = bus.CPU_SIZE;
      bus.MEM_SIGN   = bus.CPU_SIGN;
    end else if (dma_gnt) begin
      bus.MEM_ADDR2  = bus.DMA_ADDR;
      bus.MEM_DIN2   = bus.DMA_DIN;
      bus.MEM_WRITE2 = bus.DMA_WE;
      bus.MEM_READ2  = !bus.DMA_WE;
      bus.MEM_SIZE   = bus.DMA_SIZE;
      bus.MEM_SIGN   = bus.DMA_SIGN;
    end
  end

  assign bus.CPU_GNT   = cpu_gnt;
  assign bus.DMA_GNT   = dma_gnt;
  assign bus.CPU_RDATA = bus.MEM_DOUT2;
  assign bus.DMA_RDATA = bus.MEM_DOUT2;

  // Reset gating here suppresses a load granted just before reset went low,
  // since rd_pend is only cleared at the following edge.
  assign bus.CPU_RVALID = MEM_RST_N && rd_pend && !rd_owner;
  assign bus.DMA_RVALID = MEM_RST_N && rd_pend &&  rd_owner;

  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) begin
      burst_cnt <= 4'd0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      rd_pend  <= (cpu_gnt && !bus.CPU_WE) || (dma_gnt && !bus.DMA_WE);
      rd_owner <= dma_gnt;
      if (dma_gnt || !bus.DMA_REQ)
        burst_cnt <= 4'd0;
      else if (cpu_gnt && burst_cnt != BURST_MAX)
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - self-checking bench for otter_mem_arbiter

module tb_otter_mem_arbiter;

  localparam int BMAX = 4;

  logic MEM_CLK = 1'b0;
  logic MEM_RST_N = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  otter_mem_arbiter_if bus ();

  otter_mem_arbiter #(.CPU_BURST_MAX(BMAX)) dut (
    .MEM_CLK   (MEM_CLK),
    .MEM_RST_N (MEM_RST_N),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: how many CPU grants in a row DMA has been kept
  // waiting, and a queue of owners of loads issued last cycle.
  int  streak = 0;
  bit  owner_q[$];

  bit  e_cpu, e_dma;
  string pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [1:0] size, input bit sign);
    bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_ADDR = addr;
    bus.CPU_DIN = din; bus.CPU_SIZE = size; bus.CPU_SIGN = sign;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [1:0] size, input bit sign);
    bus.DMA_REQ = req; bus.DMA_WE = we; bus.DMA_ADDR = addr;
    bus.DMA_DIN = din; bus.DMA_SIZE = size; bus.DMA_SIGN = sign;
  endtask

  // Inputs are already set (1 time unit after an edge). Check mid-cycle,
  // then cross the edge and advance the model.
  task automatic step();
    logic [31:0] e_addr, e_din;
    logic [1:0]  e_size;
    bit          e_sign, e_wr, e_rd, prev_valid, prev_owner;
    #3;
    e_dma = MEM_RST_N && bus.DMA_REQ && (!bus.CPU_REQ || streak >= BMAX);
    e_cpu = MEM_RST_N && bus.CPU_REQ && !e_dma;
    e_addr = 0; e_din = 0; e_size = 0; e_sign = 0; e_wr = 0; e_rd = 0;
    if (e_cpu) begin
      e_addr = bus.CPU_ADDR; e_din = bus.CPU_DIN; e_size = bus.CPU_SIZE;
      e_sign = bus.CPU_SIGN; e_wr = bus.CPU_WE; e_rd = !bus.CPU_WE;
    end else if (e_dma) begin
      e_addr = bus.DMA_ADDR; e_din = bus.DMA_DIN; e_size = bus.DMA_SIZE;
      e_sign = bus.DMA_SIGN; e_wr = bus.DMA_WE; e_rd = !bus.DMA_WE;
    end
    prev_valid = (owner_q.size() > 0) && MEM_RST_N;
    prev_owner = (owner_q.size() > 0) ? owner_q[0] : 1'b0;
    chk("cpu_gnt", 32'(bus.CPU_GNT), 32'(e_cpu));
    chk("dma_gnt", 32'(bus.DMA_GNT), 32'(e_dma));
    chk("mem_addr2", bus.MEM_ADDR2, e_addr);
    chk("mem_din2", bus.MEM_DIN2, e_din);
    chk("mem_size", 32'(bus.MEM_SIZE), 32'(e_size));
    chk("mem_sign", 32'(bus.MEM_SIGN), 32'(e_sign));
    chk("mem_write2", 32'(bus.MEM_WRITE2), 32'(e_wr));
    chk("mem_read2", 32'(bus.MEM_READ2), 32'(e_rd));
    chk("cpu_rvalid", 32'(bus.CPU_RVALID), 32'(prev_valid && !prev_owner));
    chk("dma_rvalid", 32'(bus.DMA_RVALID), 32'(prev_valid && prev_owner));
    chk("cpu_rdata", bus.CPU_RDATA, bus.MEM_DOUT2);
    chk("dma_rdata", bus.DMA_RDATA, bus.MEM_DOUT2);
    @(posedge MEM_CLK);
    owner_q.delete();
    if (!MEM_RST_N) begin
      streak = 0;
    end else begin
      if ((e_cpu && !bus.CPU_WE) || (e_dma && !bus.DMA_WE))
        owner_q.push_back(e_dma);
      if (e_dma || !bus.DMA_REQ) streak = 0;
      else if (e_cpu) streak++;
    end
    #1;
  endtask

  initial begin
    set_cpu(0, 0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0, 0);
    bus.MEM_DOUT2 = 32'h0;
    MEM_RST_N = 1'b0;
    @(posedge MEM_CLK); #1;

    // Reset state with both requesting: nothing granted.
    set_cpu(1, 0, 32'h40, 0, 2, 0);
    set_dma(1, 0, 32'h80, 0, 2, 0);
    step();
    MEM_RST_N = 1'b1;

    // Idle: all memory outputs zero.
    set_cpu(0, 0, 32'h1234, 32'h5, 1, 1);
    set_dma(0, 0, 32'h5678, 32'h6, 1, 1);
    step();

    // CPU-only word load at 0x100, then data returns next cycle.
    set_cpu(1, 0, 32'h100, 0, 2, 0);
    step();
    set_cpu(0, 0, 0, 0, 0, 0);
    bus.MEM_DOUT2 = 32'h12345678;
    step();

    // DMA byte store: no RVALID afterwards.
    set_dma(1, 1, 32'h204, 32'hAABBCCDD, 0, 0);
    step();
    set_dma(0, 0, 0, 0, 0, 0);
    step();

    // CPU load then DMA load back to back.
    set_cpu(1, 0, 32'h300, 0, 2, 0);
    step();
    set_cpu(0, 0, 0, 0, 0, 0);
    set_dma(1, 0, 32'h400, 0, 2, 1);
    bus.MEM_DOUT2 = 32'hCAFEF00D;
    step();
    set_dma(0, 0, 0, 0, 0, 0);
    bus.MEM_DOUT2 = 32'hDEADBEEF;
    step();

    // Both held continuously: C,C,C,C,D,C,C,C,C,D.
    set_cpu(1, 0, 32'h10, 0, 2, 0);
    set_dma(1, 1, 32'h20, 32'h99, 2, 0);
    pat = "";
    for (int i = 0; i < 10; i++) begin
      step();
      pat = {pat, e_dma ? "D" : (e_cpu ? "C" : "-")};
      checks++;
      assert (bus.CPU_GNT === 1'b0 || bus.CPU_GNT === 1'b1) else begin
        failures++;
        $error("FAIL gnt_known observed=%b expected=0/1", bus.CPU_GNT);
      end
    end
    checks++;
    assert (pat == "CCCCDCCCCD") else begin
      failures++;
      $error("FAIL burst_pattern observed=%s expected=CCCCDCCCCD", pat);
    end

    // Size 3 forwarded unchanged.
    set_dma(0, 0, 0, 0, 0, 0);
    set_cpu(1, 1, 32'hFFFF0000, 32'h1, 3, 1);
    step();

    // Load granted, then reset asserted: no RVALID.
    set_cpu(1, 0, 32'h500, 0, 2, 0);
    step();
    MEM_RST_N = 1'b0;
    bus.MEM_DOUT2 = 32'h55AA55AA;
    step();
    step();
    MEM_RST_N = 1'b1;
    set_dma(1, 0, 32'h600, 0, 2, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
              $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom,
              $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      bus.MEM_DOUT2 = $urandom;
      MEM_RST_N = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
